// File: rtl/priority_encoder_8x3.sv
// Sticky 8-input priority encoder presenting one request index at a time.
// Latency: req -> pending after 1 edge, pending -> out_valid after 1 more edge.
// Backpressure: out_code/out_valid held while out_ready is low; one idle cycle per handshake.
module priority_encoder_8x3 #(
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       out_ready,
  output logic [2:0] out_code,
  output logic       out_valid,
  output logic [7:0] pending,
  output logic       dup
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PRESENT = 1'b1;

  logic [0:0] state_q, state_d;
  logic [7:0] pending_q, pending_d;
  logic [2:0] out_code_q, out_code_d;
  logic       out_valid_q, out_valid_d;
  logic       dup_q, dup_d;

  logic       hs;
  logic [7:0] served_mask;
  logic [7:0] kept;
  logic [2:0] top_idx;

  // Index of the winning set bit of v; direction chosen by LSB_FIRST.
  function automatic logic [2:0] pick(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    if (LSB_FIRST) begin
      // Scan downward so the last hit is the lowest set bit.
      for (int i = 7; i >= 0; i--) begin
        if (v[i]) idx = 3'(i);
      end
    end else begin
      // Scan upward so the last hit is the highest set bit.
      for (int i = 0; i <= 7; i++) begin
        if (v[i]) idx = 3'(i);
      end
    end
    return idx;
  endfunction

  // Handshake decode, sticky request update, duplicate detect and FSM next state.
  always_comb begin
    hs          = (state_q == ST_PRESENT) && out_ready;
    served_mask = hs ? (8'd1 << out_code_q) : 8'd0;
    kept        = pending_q & ~served_mask;
    // A fresh request on the bit being served is ORed back in, so it survives.
    pending_d   = kept | req;
    // A request onto a bit that is pending and not being served is a duplicate.
    dup_d       = |(req & kept);
    top_idx     = pick(pending_q);

    state_d     = state_q;
    out_code_d  = out_code_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        // Selection looks only at the registered pending set, never at req.
        if (pending_q != 8'd0) begin
          out_code_d  = top_idx;
          out_valid_d = 1'b1;
          state_d     = ST_PRESENT;
        end else begin
          out_valid_d = 1'b0;
        end
      end
      ST_PRESENT: begin
        // Code stays frozen until accepted, even if a higher-priority bit arrives.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State registers; reset wins over any request or handshake on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pending_q   <= 8'd0;
      out_code_q  <= 3'd0;
      out_valid_q <= 1'b0;
      dup_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      out_code_q  <= out_code_d;
      out_valid_q <= out_valid_d;
      dup_q       <= dup_d;
    end
  end

  assign out_code  = out_code_q;
  assign out_valid = out_valid_q;
  assign pending   = pending_q;
  assign dup       = dup_q;

endmodule

// File: tb/tb_priority_encoder_8x3.sv
// Bench for priority_encoder_8x3: both priority directions side by side,
// a behavioural model checked every cycle plus directed literal expectations.
module tb_priority_encoder_8x3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'd0;
  logic       out_ready = 1'b0;

  logic [2:0] code0, code1;
  logic       valid0, valid1;
  logic [7:0] pend0, pend1;
  logic       dup0, dup1;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // Model state per instance: index 0 = MSB-first, 1 = LSB-first.
  logic [7:0] m_pend  [2];
  logic       m_valid [2];
  logic [2:0] m_code  [2];
  logic       m_dup   [2];

  always #5 clk = ~clk;

  priority_encoder_8x3 #(.LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst(rst), .req(req), .out_ready(out_ready),
    .out_code(code0), .out_valid(valid0), .pending(pend0), .dup(dup0)
  );

  priority_encoder_8x3 #(.LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .req(req), .out_ready(out_ready),
    .out_code(code1), .out_valid(valid1), .pending(pend1), .dup(dup1)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Winning index by arithmetic: floor(log2) for highest bit, log2 of the isolated low bit.
  function automatic int winner(input int x, input int lsb_first);
    int low;
    if (lsb_first != 0) begin
      low = x & (-x);
      return $clog2(low);
    end
    return $clog2(x + 1) - 1;
  endfunction

  // Behavioural model advanced at each rising edge from the inputs in effect then.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int   pend_i, served_i, req_i, nxt;
      logic accept;
      if (rst) begin
        m_pend[d]  = 8'd0;
        m_valid[d] = 1'b0;
        m_code[d]  = 3'd0;
        m_dup[d]   = 1'b0;
      end else begin
        pend_i   = int'(m_pend[d]);
        req_i    = int'(req);
        accept   = m_valid[d] && out_ready;
        served_i = accept ? (1 << int'(m_code[d])) : 0;
        nxt      = (pend_i & ~served_i) | req_i;
        m_dup[d] = ((req_i & pend_i & ~served_i) != 0);
        if (!m_valid[d]) begin
          if (pend_i != 0) begin
            m_code[d]  = 3'(winner(pend_i, d));
            m_valid[d] = 1'b1;
          end
        end else if (accept) begin
          m_valid[d] = 1'b0;
        end
        m_pend[d] = 8'(nxt);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("m0_pending", pend0, m_pend[0]);
      check("m0_valid", {7'd0, valid0}, {7'd0, m_valid[0]});
      check("m0_dup", {7'd0, dup0}, {7'd0, m_dup[0]});
      if (m_valid[0]) check("m0_code", {5'd0, code0}, {5'd0, m_code[0]});
      check("m1_pending", pend1, m_pend[1]);
      check("m1_valid", {7'd0, valid1}, {7'd0, m_valid[1]});
      check("m1_dup", {7'd0, dup1}, {7'd0, m_dup[1]});
      if (m_valid[1]) check("m1_code", {5'd0, code1}, {5'd0, m_code[1]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int q0[$];
    int q1[$];
    int t0[$];
    int exp_msb[4];
    int exp_lsb[4];
    int exp_t[4];
    exp_msb = '{7, 5, 2, 0};
    exp_lsb = '{0, 2, 5, 7};
    exp_t   = '{1, 3, 5, 7};

    // Reset, with a request held during reset that must be lost.
    rst = 1'b1; req = 8'h40; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0; req = 8'h00;
    cmp_en = 1'b1;
    check("rst_pending", pend0, 8'h00);
    check("rst_valid", {7'd0, valid0}, 8'h00);
    check("rst_code", {5'd0, code0}, 8'h00);
    check("rst_dup", {7'd0, dup0}, 8'h00);
    tick();
    check("rst_req_lost", pend0, 8'h00);

    // Single request: two-edge latency, cleared after handshake.
    out_ready = 1'b1; req = 8'h08;
    tick();
    req = 8'h00;
    check("single_pend", pend0, 8'h08);
    check("single_valid_early", {7'd0, valid0}, 8'h00);
    tick();
    check("single_valid", {7'd0, valid0}, 8'h01);
    check("single_code", {5'd0, code0}, 8'h03);
    tick();
    check("single_done_pend", pend0, 8'h00);
    check("single_done_valid", {7'd0, valid0}, 8'h00);

    // Priority order both directions, one code every two cycles.
    req = 8'hA5;
    tick();
    req = 8'h00;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (valid0) begin q0.push_back(int'(code0)); t0.push_back(i); end
      if (valid1) q1.push_back(int'(code1));
    end
    check("order_cnt_msb", 8'(q0.size()), 8'd4);
    check("order_cnt_lsb", 8'(q1.size()), 8'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < q0.size()) check("order_msb", 8'(q0[i]), 8'(exp_msb[i]));
      if (i < q1.size()) check("order_lsb", 8'(q1[i]), 8'(exp_lsb[i]));
      if (i < t0.size()) check("order_spacing", 8'(t0[i]), 8'(exp_t[i]));
    end
    check("order_drained", pend0, 8'h00);

    // Backpressure: code 4 held while a higher-priority bit arrives.
    out_ready = 1'b0; req = 8'h10;
    tick();
    req = 8'h00;
    tick();
    check("bp_code4", {5'd0, code0}, 8'h04);
    req = 8'h80;
    tick();
    req = 8'h00;
    tick(); tick();
    check("bp_hold_code", {5'd0, code0}, 8'h04);
    check("bp_hold_valid", {7'd0, valid0}, 8'h01);
    check("bp_hold_pend", pend0, 8'h90);
    check("bp_hold_code_lsb", {5'd0, code1}, 8'h04);
    out_ready = 1'b1;
    tick();
    check("bp_hs_pend", pend0, 8'h80);
    check("bp_hs_valid", {7'd0, valid0}, 8'h00);
    tick();
    check("bp_next_code", {5'd0, code0}, 8'h07);
    tick();
    out_ready = 1'b0;
    check("bp_drained", pend0, 8'h00);

    // Serve/re-request collision on bit 3.
    req = 8'h08;
    tick();
    req = 8'h00;
    tick();
    check("coll_code", {5'd0, code0}, 8'h03);
    out_ready = 1'b1; req = 8'h08;
    tick();
    check("coll_pend_kept", pend0, 8'h08);
    check("coll_no_dup", {7'd0, dup0}, 8'h00);
    check("coll_valid_low", {7'd0, valid0}, 8'h00);
    out_ready = 1'b0; req = 8'h00;
    tick();
    check("coll_again_valid", {7'd0, valid0}, 8'h01);
    check("coll_again_code", {5'd0, code0}, 8'h03);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("coll_drained", pend0, 8'h00);

    // Duplicate detect on a held pending bit.
    req = 8'h02;
    tick();
    req = 8'h00;
    tick();
    check("dup_code", {5'd0, code0}, 8'h01);
    req = 8'h02;
    tick();
    req = 8'h00;
    check("dup_pulse", {7'd0, dup0}, 8'h01);
    check("dup_pend", pend0, 8'h02);
    tick();
    check("dup_one_cycle", {7'd0, dup0}, 8'h00);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("dup_drained", pend0, 8'h00);

    // Reset mid-operation beats handshake and request.
    req = 8'hFF;
    tick();
    req = 8'h00;
    tick();
    check("midrst_valid", {7'd0, valid0}, 8'h01);
    check("midrst_pend", pend0, 8'hFF);
    check("midrst_code_lsb", {5'd0, code1}, 8'h00);
    rst = 1'b1; out_ready = 1'b1; req = 8'hFF;
    tick();
    check("midrst_pend0", pend0, 8'h00);
    check("midrst_valid0", {7'd0, valid0}, 8'h00);
    check("midrst_code0", {5'd0, code0}, 8'h00);
    check("midrst_dup0", {7'd0, dup0}, 8'h00);
    rst = 1'b0; req = 8'h00; out_ready = 1'b0;
    tick();
    check("midrst_lost", pend0, 8'h00);

    // Mixed traffic checked by the model each cycle.
    for (int i = 0; i < 400; i++) begin
      req       = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      out_ready = 1'($urandom_range(0, 1));
      rst       = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0; req = 8'h00; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("final_drained", pend0, 8'h00);

    @(posedge clk);
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
